dmem_responder: RTL and testbench

Multi-cycle data-memory responder that serves load/store requests issued by the pipeline's memory stage. It accepts one request at a time, holds the pipeline with `stall` for a configurable latency, and then commits the write or returns the read word with a one-cycle `rsp_valid` pulse. It replaces the single-cycle data memory behind the memory stage, so the memory subsystem can be modelled with realistic latency.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_array.sv | 23 ++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int CNT_W = 4;

    // Every bit of rsp_rdata takes this value at reset and on non-load responses
    localparam logic RDATA_RST_BIT = 1'b0;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage (master) and the responder (slave).
interface dmem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              stall;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, stall, rsp_valid, rsp_rdata, err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, stall, rsp_valid, rsp_rdata, err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with registered read; contents are not reset.
module dmem_array #(
    parameter  int DEPTH = 16384,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: stalls the pipeline for LATENCY cycles, then a one-cycle response.
// Build option: define DMEM_ALIGN_CHECK_EN to reject misaligned requests with err instead of accessing.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave dmem
);
    // state | meaning
    // IDLE  | ready; a valid request is latched on the next edge
    // BUSY  | counting down the remaining latency on the latched request
    // RESP  | rsp_valid for one cycle, then back to IDLE

    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 2 ** WORD_W;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_RESP = RESP;

    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_sel_q, rd_sel_d;
    logic              err_q, err_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WORD_W-1:0] rd_addr_q;

    logic              accept, access;
    logic              acc_wr, acc_bad;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              ram_we;
    logic [WORD_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign accept = (state_q == ST_IDLE) && dmem.req_valid;
    assign access = ((state_q == ST_BUSY) && (cnt_q == '0)) || (accept && (LATENCY == 1));

    // With LATENCY=1 the access edge is also the accept edge, so the live request is used
    assign acc_wr    = (state_q == ST_IDLE) ? dmem.req_wr    : wr_q;
    assign acc_addr  = (state_q == ST_IDLE) ? dmem.req_addr  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? dmem.req_wdata : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_bad = is_misaligned(acc_addr[1:0]);
`else
    logic unused_byte_off;
    assign unused_byte_off = ^acc_addr[1:0];
    assign acc_bad         = 1'b0;
`endif

    // Between accesses the RAM keeps re-reading the last accessed word, so its output holds
    assign ram_we   = access && acc_wr && !acc_bad && !rst;
    assign ram_addr = access ? acc_addr[ADDR_W-1:2] : rd_addr_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_sel_d = rd_sel_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (dmem.req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (access) begin
            rd_sel_d = !acc_wr && !acc_bad;
            err_d    = acc_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_sel_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_sel_q <= rd_sel_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= dmem.req_wr;
            addr_q  <= dmem.req_addr;
            wdata_q <= dmem.req_wdata;
        end
        if (access) begin
            rd_addr_q <= acc_addr[ADDR_W-1:2];
        end
    end

    assign dmem.req_ready = (state_q == ST_IDLE);
    assign dmem.stall     = accept || (state_q == ST_BUSY);
    assign dmem.rsp_valid = (state_q == ST_RESP);
    assign dmem.rsp_rdata = rd_sel_q ? ram_rdata : {DATA_W{RDATA_RST_BIT}};
    assign dmem.err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=4 and LATENCY=1 instances against a transaction-level model.
module tb_dmem_responder;

    localparam int AW = 16;
    localparam int DW = 32;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          trst [2];
    logic          tv   [2];
    logic          twr  [2];
    logic [AW-1:0] ta   [2];
    logic [DW-1:0] td   [2];

    dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    assign bus0.req_valid = tv[0];
    assign bus0.req_wr    = twr[0];
    assign bus0.req_addr  = ta[0];
    assign bus0.req_wdata = td[0];
    assign bus1.req_valid = tv[1];
    assign bus1.req_wr    = twr[1];
    assign bus1.req_addr  = ta[1];
    assign bus1.req_wdata = td[1];

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(4)) u_dut4 (
        .clk  (clk),
        .rst  (trst[0]),
        .dmem (bus0)
    );

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_dut1 (
        .clk  (clk),
        .rst  (trst[1]),
        .dmem (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic o_ready(input int k);
        return (k == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction
    function automatic logic o_stall(input int k);
        return (k == 0) ? bus0.stall : bus1.stall;
    endfunction
    function automatic logic o_rv(input int k);
        return (k == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    endfunction
    function automatic logic [DW-1:0] o_rdata(input int k);
        return (k == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
    endfunction
    function automatic logic o_err(input int k);
        return (k == 0) ? bus0.err : bus1.err;
    endfunction

    // Transaction model: a request waits LATENCY-1 edges after acceptance, then one response cycle
    bit            m_pend  [2];
    bit            m_resp  [2];
    bit            m_acc   [2];
    bit            m_known [2];
    int            m_left  [2];
    bit            m_wr    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rd    [2];
    bit            m_err   [2];
    logic [DW-1:0] m_mem   [int];

    function automatic int lat(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_step(input int k, input logic r, input logic v, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        int key;
        m_acc[k] = 1'b0;
        if (r) begin
            m_pend[k] = 0; m_resp[k] = 0; m_rd[k] = '0; m_known[k] = 1; m_err[k] = 0;
            return;
        end
        if (m_resp[k]) begin
            m_resp[k] = 0; m_err[k] = 0;
            return;
        end
        if (!m_pend[k]) begin
            if (!v) return;
            m_pend[k] = 1; m_wr[k] = w; m_addr[k] = a; m_wdata[k] = d;
            m_left[k] = lat(k) - 1; m_acc[k] = 1;
        end else begin
            m_left[k]--;
        end
        if (m_left[k] == 0) begin
            key = k * 65536 + int'(m_addr[k][AW-1:2]);
            m_pend[k] = 0; m_resp[k] = 1; m_known[k] = 1;
            if (ALIGN && m_addr[k][1:0] != 2'b00) begin
                m_err[k] = 1; m_rd[k] = '0;
            end else begin
                m_err[k] = 0;
                if (m_wr[k]) begin
                    m_mem[key] = m_wdata[k];
                    m_rd[k] = '0;
                end else if (m_mem.exists(key)) begin
                    m_rd[k] = m_mem[key];
                end else begin
                    m_known[k] = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k, trst[k], tv[k], twr[k], ta[k], td[k]);
    end

    task automatic compare(input int k);
        bit idle;
        idle = !m_pend[k] && !m_resp[k];
        check($sformatf("ready[%0d]", k), {31'b0, o_ready(k)}, {31'b0, idle});
        check($sformatf("stall[%0d]", k), {31'b0, o_stall(k)}, {31'b0, (idle && tv[k]) || m_pend[k]});
        check($sformatf("rsp_valid[%0d]", k), {31'b0, o_rv(k)}, {31'b0, m_resp[k]});
        if (m_known[k]) check($sformatf("rsp_rdata[%0d]", k), o_rdata(k), m_rd[k]);
        if (m_resp[k]) check($sformatf("err[%0d]", k), {31'b0, o_err(k)}, {31'b0, m_err[k]});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare(0);
            compare(1);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a request, returns the presenting cycle and the response cycle indices
    task automatic do_req(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit scramble, output int pc, output int rc);
        pc = -1;
        rc = -1;
        tv[k] = 1'b1; twr[k] = w; ta[k] = a; td[k] = d;
        for (int n = 0; n < 40 && pc < 0; n++) begin
            @(posedge clk);
            #1;
            if (m_acc[k]) pc = cyc - 1;
        end
        check($sformatf("accepted[%0d]", k), {31'b0, pc >= 0}, 32'd1);
        if (pc < 0) begin
            tv[k] = 1'b0;
            return;
        end
        if (scramble) begin
            ta[k] = a ^ 16'h0004;
            td[k] = ~d;
        end else begin
            tv[k] = 1'b0;
        end
        for (int n = 0; n < 40 && rc < 0; n++) begin
            if (o_rv(k)) rc = cyc;
            else tick(1);
        end
        tv[k] = 1'b0;
        check($sformatf("responded[%0d]", k), {31'b0, rc >= 0}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, r, p2, r2, n_rv;
        for (int k = 0; k < 2; k++) begin
            trst[k] = 1'b1; tv[k] = 1'b0; twr[k] = 1'b0; ta[k] = '0; td[k] = '0;
            m_known[k] = 1'b0;
        end
        tick(3);
        trst[0] = 1'b0;
        trst[1] = 1'b0;
        chk_en = 1'b1;

        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_ready[%0d]", k), {31'b0, o_ready(k)}, 32'd1);
            check($sformatf("reset_rv[%0d]", k), {31'b0, o_rv(k)}, 32'd0);
            check($sformatf("reset_rdata[%0d]", k), o_rdata(k), 32'h0);
            check($sformatf("reset_err[%0d]", k), {31'b0, o_err(k)}, 32'd0);
        end

        do_req(0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, p, r);
        check("l4_store_latency", r - p, 32'd4);
        check("l4_store_rdata", o_rdata(0), 32'h0);
        tick(1);
        do_req(0, 1'b0, 16'h0010, 32'h0, 1'b0, p, r);
        check("l4_load_latency", r - p, 32'd4);
        check("l4_load_data", o_rdata(0), 32'hDEADBEEF);
        tick(2);
        check("l4_rdata_hold", o_rdata(0), 32'hDEADBEEF);

        do_req(1, 1'b1, 16'h00FC, 32'h12345678, 1'b0, p, r);
        check("l1_store_latency", r - p, 32'd1);
        check("l1_no_stall_in_resp", {31'b0, o_stall(1)}, 32'd0);
        tick(1);
        do_req(1, 1'b0, 16'h00FC, 32'h0, 1'b0, p, r);
        check("l1_load_latency", r - p, 32'd1);
        check("l1_load_data", o_rdata(1), 32'h12345678);
        tick(1);

        do_req(0, 1'b1, 16'h0030, 32'h00003030, 1'b0, p, r);
        do_req(0, 1'b0, 16'h0010, 32'h0, 1'b0, p2, r2);
        check("b2b_accept_after_resp", p2 - r, 32'd1);
        check("b2b_resp_gap", r2 - r, 32'd5);
        check("b2b_load_data", o_rdata(0), 32'hDEADBEEF);
        tick(1);

        do_req(0, 1'b1, 16'h0020, 32'h11112222, 1'b0, p, r);
        tick(1);
        tv[0] = 1'b1; twr[0] = 1'b1; ta[0] = 16'h0020; td[0] = 32'hAAAA5555;
        p = -1;
        for (int n = 0; n < 10 && p < 0; n++) begin
            tick(1);
            if (m_acc[0]) p = cyc;
        end
        check("rst_store_accepted", {31'b0, p >= 0}, 32'd1);
        tv[0] = 1'b0;
        n_rv = 0;
        tick(1);
        trst[0] = 1'b1;
        if (o_rv(0)) n_rv++;
        tick(1);
        trst[0] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (o_rv(0)) n_rv++;
            tick(1);
        end
        check("rst_no_response", n_rv, 32'd0);
        check("rst_ready", {31'b0, o_ready(0)}, 32'd1);
        do_req(0, 1'b0, 16'h0020, 32'h0, 1'b0, p, r);
        check("rst_store_dropped", o_rdata(0), 32'h11112222);
        tick(1);

        do_req(0, 1'b1, 16'h0044, 32'h44444444, 1'b0, p, r);
        tick(1);
        do_req(0, 1'b1, 16'h0040, 32'h77778888, 1'b1, p, r);
        check("opchg_latency", r - p, 32'd4);
        tick(1);
        do_req(0, 1'b0, 16'h0040, 32'h0, 1'b0, p, r);
        check("opchg_latched_data", o_rdata(0), 32'h77778888);
        tick(1);
        do_req(0, 1'b0, 16'h0044, 32'h0, 1'b0, p, r);
        check("opchg_other_word", o_rdata(0), 32'h44444444);
        tick(1);

        do_req(0, 1'b1, 16'h0020, 32'h0BADF00D, 1'b0, p, r);
        tick(1);
        do_req(0, 1'b1, 16'h0022, 32'hCAFEF00D, 1'b0, p, r);
        check("align_err", {31'b0, o_err(0)}, {31'b0, ALIGN});
        check("align_rdata", o_rdata(0), 32'h0);
        tick(1);
        do_req(0, 1'b0, 16'h0020, 32'h0, 1'b0, p, r);
        check("align_word_after", o_rdata(0), ALIGN ? 32'h0BADF00D : 32'hCAFEF00D);
        check("align_load_err", {31'b0, o_err(0)}, 32'd0);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
